lfsr_stream_checker: RTL

Downstream consumer of the 4-bit LFSR/BRAM sample stream. It takes each newly written sample and predicts the next one using the same shift/feedback rule as the generator (next = {cur[2:0], cur[3]^cur[1]}). It reports lock status, mismatch events, a saturating error count and the measured sequence period. It sits after the BRAM write path and is clocked by the same fast system clock, with one sample strobe per BRAM write.

---
 rtl/lfsr_stream_checker_if.sv | 36 +++
 rtl/lfsr_stream_checker.sv | 139 +++++++++++++
 2 files changed

// File: rtl/lfsr_stream_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_stream_checker_if
// Description : Sample-stream and status bundle for lfsr_stream_checker.
//               master : sample source (drives sample_valid, sample_data,
//                        clear; observes the status outputs)
//               slave  : the checker (consumes samples, drives status)
//               Signals: sample_valid, sample_data[3:0], clear, locked,
//                        error_pulse, err_count[ERR_W-1:0], zero_stuck,
//                        period[3:0], period_valid
// Revision    : 1.0 - initial release
// ============================================================================
interface lfsr_stream_checker_if #(
    parameter int ERR_W = 8
);
    logic             sample_valid;
    logic [3:0]       sample_data;
    logic             clear;
    logic             locked;
    logic             error_pulse;
    logic [ERR_W-1:0] err_count;
    logic             zero_stuck;
    logic [3:0]       period;
    logic             period_valid;

    modport master (
        output sample_valid, sample_data, clear,
        input  locked, error_pulse, err_count, zero_stuck, period, period_valid
    );

    modport slave (
        input  sample_valid, sample_data, clear,
        output locked, error_pulse, err_count, zero_stuck, period, period_valid
    );
endinterface
`default_nettype wire

// File: rtl/lfsr_stream_checker.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_stream_checker
// Description : Tracks a 4-bit LFSR sample stream (next = {cur[2:0],
//               cur[3]^cur[1]}), reporting lock, mismatch/zero error pulses,
//               a saturating error count, a sticky zero flag and the
//               measured sequence period.
//               Ports: clk, reset (async, active-high),
//                      s (lfsr_stream_checker_if.slave) - sample stream in,
//                      status out. All outputs registered, latency 1.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_stream_checker #(
    parameter int LOCK_COUNT = 4,
    parameter int ERR_W      = 8
) (
    input wire                    clk,
    input wire                    reset,
    lfsr_stream_checker_if.slave  s
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam logic [3:0] c_lock    = 4'(LOCK_COUNT);
    localparam logic [3:0] c_per_max = 4'd15;

    state_t           r_state;
    logic [3:0]       r_expected;
    logic [3:0]       r_match_cnt;
    logic [3:0]       r_per_cnt;
    logic [3:0]       r_anchor;
    logic             r_locked;
    logic             r_error_pulse;
    logic [ERR_W-1:0] r_err_count;
    logic             r_zero_stuck;
    logic [3:0]       r_period;
    logic             r_period_valid;

    logic [3:0]       w_pred;
    logic [ERR_W-1:0] w_err_inc;
    logic             w_match;

    // Prediction of the sample following the current one.
    assign w_pred    = {s.sample_data[2:0], s.sample_data[3] ^ s.sample_data[1]};
    assign w_match   = (s.sample_data == r_expected);
    assign w_err_inc = (r_err_count == {ERR_W{1'b1}}) ? r_err_count
                                                      : r_err_count + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_expected     <= 4'd0;
            r_match_cnt    <= 4'd0;
            r_per_cnt      <= 4'd0;
            r_anchor       <= 4'd0;
            r_locked       <= 1'b0;
            r_error_pulse  <= 1'b0;
            r_err_count    <= '0;
            r_zero_stuck   <= 1'b0;
            r_period       <= 4'd0;
            r_period_valid <= 1'b0;
        end else begin
            r_error_pulse <= 1'b0;
            if (s.sample_valid) begin
                if (s.sample_data == 4'd0) begin
                    // All-zero is the LFSR lock-up state: always an error.
                    r_state       <= ST_IDLE;
                    r_locked      <= 1'b0;
                    r_zero_stuck  <= 1'b1;
                    r_err_count   <= w_err_inc;
                    r_error_pulse <= 1'b1;
                end else begin
                    case (r_state)
                        ST_IDLE: begin
                            r_expected  <= w_pred;
                            r_match_cnt <= 4'd0;
                            r_state     <= ST_ACQUIRE;
                        end
                        ST_ACQUIRE: begin
                            r_expected <= w_pred;
                            if (w_match) begin
                                r_match_cnt <= r_match_cnt + 4'd1;
                                if (r_match_cnt + 4'd1 == c_lock) begin
                                    r_state   <= ST_LOCKED;
                                    r_locked  <= 1'b1;
                                    r_anchor  <= s.sample_data;
                                    r_per_cnt <= 4'd1;
                                end
                            end else begin
                                // Silent reseed while acquiring.
                                r_match_cnt <= 4'd0;
                            end
                        end
                        ST_LOCKED: begin
                            r_expected <= w_pred;
                            if (w_match) begin
                                if (s.sample_data == r_anchor) begin
                                    r_period       <= r_per_cnt;
                                    r_period_valid <= 1'b1;
                                    r_per_cnt      <= 4'd1;
                                end else if (r_per_cnt != c_per_max) begin
                                    r_per_cnt <= r_per_cnt + 4'd1;
                                end
                            end else begin
                                r_error_pulse <= 1'b1;
                                r_err_count   <= w_err_inc;
                                r_match_cnt   <= 4'd0;
                                r_state       <= ST_ACQUIRE;
                                r_locked      <= 1'b0;
                            end
                        end
                        default: begin
                            r_state  <= ST_IDLE;
                            r_locked <= 1'b0;
                        end
                    endcase
                end
            end
            // Clear overrides counter/flag updates but not the FSM.
            if (s.clear) begin
                r_err_count    <= '0;
                r_zero_stuck   <= 1'b0;
                r_period       <= 4'd0;
                r_period_valid <= 1'b0;
            end
        end
    end

    assign s.locked       = r_locked;
    assign s.error_pulse  = r_error_pulse;
    assign s.err_count    = r_err_count;
    assign s.zero_stuck   = r_zero_stuck;
    assign s.period       = r_period;
    assign s.period_valid = r_period_valid;
endmodule
`default_nettype wire
